// File: rtl/trinity_pkg.sv
// Shared definitions for the trinity_tile sequence generator: mode encodings,
// LFSR tap default, ui_in bit-field positions and the LFSR step function.
package trinity_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_RSVD     = 2;
  localparam int CTRL_HOLD     = 3;
  localparam int CTRL_PRE_LSB  = 4;

  // An all-zero register would stick forever, so it is kicked to 1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] taps);
    if (s == 8'h00) return 8'h01;
    return {s[6:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/trinity_prescaler.sv
// Divides enabled edges by (p_i+1); tick_o is combinational from pcnt_q, p_i and en_i.
// No backpressure: pcnt_q holds whenever en_i is low.
module trinity_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [3:0] p_i,
  output logic       tick_o
);

  logic [3:0] pcnt_q;
  logic [3:0] pcnt_d;

  // The >= compare lets a lowered P take effect without waiting for a wrap.
  always_comb begin
    pcnt_d = pcnt_q;
    tick_o = 1'b0;
    if (en_i) begin
      if (pcnt_q >= p_i) begin
        tick_o = 1'b1;
        pcnt_d = 4'd0;
      end else begin
        pcnt_d = pcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= 4'd0;
    else        pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/trinity_tile.sv
// 8-bit up/down/LFSR/load sequence generator; state register drives uo_out (1-cycle latency at P=0).
// No backpressure: ena low or hold high freezes state and prescaler in place.
module trinity_tile
  import trinity_pkg::*;
#(
  parameter logic [7:0] LFSR_TAPS = LFSR_TAPS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] state_q;
  logic [7:0] state_d;
  logic       step_en;
  logic       tick;
  mode_e      mode;
  logic       unused_rsvd;

  assign mode        = mode_e'(ui_in[CTRL_MODE_LSB +: 2]);
  assign step_en     = ena & ~ui_in[CTRL_HOLD];
  assign unused_rsvd = ui_in[CTRL_RSVD];

  trinity_prescaler u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (step_en),
    .p_i    (ui_in[CTRL_PRE_LSB +: 4]),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (mode)
        MODE_UP:   state_d = state_q + 8'd1;
        MODE_DOWN: state_d = state_q - 8'd1;
        MODE_LFSR: state_d = lfsr_next(state_q, LFSR_TAPS);
        MODE_LOAD: state_d = uio_in;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= 8'h00;
    else        state_q <= state_d;
  end

  assign uo_out  = state_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_trinity_tile.sv
// Scoreboard bench for trinity_tile: a behavioural model queues the expected
// uo_out for every clock edge, popped and compared just after the edge.
module tb_trinity_tile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_state;
  logic [3:0] m_pcnt;

  trinity_tile dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Feedback written out bit by bit: x^8+x^6+x^5+x^4+1 on a left shift.
  function automatic logic [7:0] model_lfsr(input logic [7:0] s);
    logic fb;
    if (s == 8'h00) return 8'h01;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  function automatic void model_edge();
    logic tk;
    tk = 1'b0;
    if (rst_n && ena && !ui_in[3]) begin
      if (m_pcnt >= ui_in[7:4]) begin
        tk = 1'b1;
        m_pcnt = 4'd0;
      end else begin
        m_pcnt = m_pcnt + 4'd1;
      end
    end
    if (tk) begin
      case (ui_in[1:0])
        2'b00:   m_state = m_state + 8'd1;
        2'b01:   m_state = m_state - 8'd1;
        2'b10:   m_state = model_lfsr(m_state);
        default: m_state = uio_in;
      endcase
    end
  endfunction

  task automatic step(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      model_edge();
      exp_q.push_back(m_state);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk({tag, "_empty"}, 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        chk(tag, {8'h00, uo_out}, {8'h00, e});
      end
    end
  endtask

  task automatic set_ctrl(input logic [3:0] p, input logic hold, input logic [1:0] mode,
                          input logic [7:0] ld);
    ui_in  = {p, hold, 1'b0, mode};
    uio_in = ld;
  endtask

  initial begin
    int cnt;
    logic seen_zero;

    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    m_state = 8'h00; m_pcnt = 4'd0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_uo_out", {8'h00, uo_out}, 16'h0000);
    chk("rst_uio_out", {8'h00, uio_out}, 16'h0000);
    chk("rst_uio_oe", {8'h00, uio_oe}, 16'h0000);

    rst_n = 1'b1; ena = 1'b1;
    step(300, "up_run");
    chk("up_300", {8'h00, uo_out}, 16'd44);

    set_ctrl(4'd0, 1'b0, 2'b11, 8'h00); step(1, "load0");
    set_ctrl(4'd0, 1'b0, 2'b01, 8'h00); step(1, "down1");
    chk("down_wrap", {8'h00, uo_out}, 16'h00FF);
    step(2, "down3");
    chk("down_fd", {8'h00, uo_out}, 16'h00FD);
    set_ctrl(4'd0, 1'b0, 2'b11, 8'hFF); step(1, "loadff");
    set_ctrl(4'd0, 1'b0, 2'b00, 8'h00); step(1, "up_wrap_run");
    chk("up_wrap", {8'h00, uo_out}, 16'h0000);

    set_ctrl(4'd3, 1'b0, 2'b00, 8'h00); step(12, "pre_run");
    chk("pre_12", {8'h00, uo_out}, 16'd3);
    ena = 1'b0; step(10, "pre_off");
    chk("pre_frozen", {8'h00, uo_out}, 16'd3);
    ena = 1'b1; step(4, "pre_resume");
    chk("pre_resumed", {8'h00, uo_out}, 16'd4);

    set_ctrl(4'd0, 1'b0, 2'b11, 8'h00); step(1, "load0b");
    set_ctrl(4'd0, 1'b0, 2'b10, 8'h00);
    step(1, "lfsr"); chk("lfsr_escape", {8'h00, uo_out}, 16'h0001);
    step(1, "lfsr"); chk("lfsr_02", {8'h00, uo_out}, 16'h0002);
    step(1, "lfsr"); chk("lfsr_04", {8'h00, uo_out}, 16'h0004);
    step(1, "lfsr"); chk("lfsr_08", {8'h00, uo_out}, 16'h0008);
    cnt = 3; seen_zero = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1, "lfsr_cycle");
      cnt++;
      if (uo_out == 8'h00) seen_zero = 1'b1;
      if (uo_out == 8'h01) break;
    end
    chk("lfsr_period", cnt[15:0], 16'd255);
    chk("lfsr_nonzero", {15'd0, seen_zero}, 16'd0);

    set_ctrl(4'd0, 1'b0, 2'b11, 8'hA5); step(1, "load_a5");
    chk("load_a5", {8'h00, uo_out}, 16'h00A5);
    set_ctrl(4'd0, 1'b1, 2'b00, 8'hA5); step(5, "hold");
    chk("hold_a5", {8'h00, uo_out}, 16'h00A5);
    set_ctrl(4'd0, 1'b0, 2'b00, 8'hA5); step(1, "unhold");
    chk("unhold_a6", {8'h00, uo_out}, 16'h00A6);

    set_ctrl(4'd0, 1'b0, 2'b11, 8'h36); step(1, "load36");
    set_ctrl(4'd0, 1'b0, 2'b00, 8'h00); step(1, "to37");
    chk("pre_arst_37", {8'h00, uo_out}, 16'h0037);
    #2 rst_n = 1'b0;
    #1 chk("arst_async", {8'h00, uo_out}, 16'h0000);
    m_state = 8'h00; m_pcnt = 4'd0;
    #1 rst_n = 1'b1;
    step(1, "post_arst");
    chk("post_arst_1", {8'h00, uo_out}, 16'h0001);

    chk("queue_drained", exp_q.size(), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
